// File: rtl/sort_pkg.sv
// Shared types and helpers for the sorter result path.
// Combinational helpers only; no latency or flow control here.
// The element count is fixed at 8; the element width is a per-module parameter up to MAX_BW.
package sort_pkg;

    localparam int NUM_ELEMS  = 8;
    localparam int IDX_W      = 3;
    localparam int MAX_BW     = 64;
    localparam int MAX_WORD_W = NUM_ELEMS * MAX_BW;

    typedef enum logic {IDLE, STREAM} unpack_state_t;

    // Extracts slice i of width bw; callers zero-extend the packed word to MAX_WORD_W.
    function automatic logic [MAX_BW-1:0] elem(input logic [MAX_WORD_W-1:0] word,
                                               input int unsigned i,
                                               input int unsigned bw);
        logic [MAX_WORD_W-1:0] sh;
        logic [MAX_BW-1:0]     mask;
        sh   = word >> (i * bw);
        mask = (MAX_BW'(1) << bw) - 1'b1;
        return sh[MAX_BW-1:0] & mask;
    endfunction

endpackage

// File: rtl/sort_order_check.sv
// Flags any adjacent pair where a later element exceeds an earlier one.
// Purely combinational, zero latency.
// No flow control; the caller decides when to sample err.
module sort_order_check
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic [NUM_ELEMS*BITWIDTH-1:0] word,
    output logic                          err
);

    always_comb begin
        err = 1'b0;
        for (int i = 0; i < NUM_ELEMS - 1; i++) begin
            if (elem(MAX_WORD_W'(word), i, BITWIDTH) < elem(MAX_WORD_W'(word), i + 1, BITWIDTH))
                err = 1'b1;
        end
    end

endmodule

// File: rtl/sorted_word_unpacker.sv
// Captures a sorter result on its valid rising edge and streams the 8 elements out, e0 first.
// Latency: first element valid one cycle after the rise is sampled; 8 elements in 8 cycles at full rate.
// Backpressure: holds data while out_ready is low; results arriving mid-stream are dropped (overrun). SORT_ORDER_CHECK_EN adds order_err.
module sorted_word_unpacker
    import sort_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_ELEMS*BITWIDTH:0]   in_word,
    output logic [BITWIDTH-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          busy,
    output logic                          overrun,
    output logic                          order_err
);

    localparam int               WORD_W   = NUM_ELEMS * BITWIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    unpack_state_t     state_q, state_nxt;
    logic              vld_q;
    logic [WORD_W-1:0] buf_q;
    logic [IDX_W-1:0]  idx_q;
    logic              overrun_q;
    logic              in_vld, rise, hs, at_last, capture;

    assign in_vld  = in_word[WORD_W];
    assign rise    = in_vld & ~vld_q;
    assign hs      = out_valid & out_ready;
    assign at_last = (idx_q == LAST_IDX);
    // A rise coinciding with the final handshake chains straight into the next stream.
    assign capture = rise & ((state_q == IDLE) | (hs & at_last));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (capture) state_nxt = STREAM;
            STREAM:  if (hs && at_last && !capture) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == STREAM);
        busy      = out_valid;
        out_last  = out_valid & at_last;
        out_idx   = idx_q;
        overrun   = overrun_q;
        out_data  = out_valid ? BITWIDTH'(elem(MAX_WORD_W'(buf_q), 32'(idx_q), BITWIDTH)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= 1'b0;
            buf_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            vld_q <= in_vld;
            if (capture) begin
                buf_q <= in_word[WORD_W-1:0];
                idx_q <= '0;
            end else if (hs) begin
                idx_q <= at_last ? '0 : idx_q + 1'b1;
            end
            if (rise && (state_q == STREAM) && !capture)
                overrun_q <= 1'b1;
        end
    end

`ifdef SORT_ORDER_CHECK_EN
    logic chk_err;
    logic order_err_q;

    sort_order_check #(.BITWIDTH(BITWIDTH)) u_order_check (
        .word (in_word[WORD_W-1:0]),
        .err  (chk_err)
    );

    always_ff @(posedge clk) begin
        if (reset)        order_err_q <= 1'b0;
        else if (capture) order_err_q <= chk_err;
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule
